// File: rtl/line_filter_edge_detect.sv
// Per-line glitch filter with programmable rise/fall hold times and registered
// single-cycle edge pulses on each filtered transition.
module line_filter_edge_detect #(
    parameter int unsigned LINE_NUM     = 3,
    parameter int unsigned FILTER_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [LINE_NUM-1:0]              iv_linein,
    input  logic                             i_filter_en,
    input  logic [LINE_NUM*FILTER_WIDTH-1:0] iv_filter_rise,
    input  logic [LINE_NUM*FILTER_WIDTH-1:0] iv_filter_fall,
    output logic [LINE_NUM-1:0]              ov_linein_filter,
    output logic [LINE_NUM-1:0]              ov_rise_pulse,
    output logic [LINE_NUM-1:0]              ov_fall_pulse
);

    logic [LINE_NUM-1:0][FILTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [LINE_NUM-1:0][FILTER_WIDTH-1:0] thr;
    logic [LINE_NUM-1:0]                   filt_q, filt_d;
    logic [LINE_NUM-1:0]                   rise_q, rise_d;
    logic [LINE_NUM-1:0]                   fall_q, fall_d;

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        rise_d = '0;
        fall_d = '0;
        thr    = '0;
        for (int i = 0; i < LINE_NUM; i++) begin
            // The threshold in force depends on which edge the line is heading toward.
            if (i_filter_en) begin
                thr[i] = filt_q[i] ? iv_filter_fall[i*FILTER_WIDTH +: FILTER_WIDTH]
                                   : iv_filter_rise[i*FILTER_WIDTH +: FILTER_WIDTH];
            end
            if (iv_linein[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr[i]) begin
                filt_d[i] = iv_linein[i];
                cnt_d[i]  = '0;
                rise_d[i] = iv_linein[i];
                fall_d[i] = ~iv_linein[i];
            end else if (cnt_q[i] != {FILTER_WIDTH{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + FILTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign ov_linein_filter = filt_q;
    assign ov_rise_pulse    = rise_q;
    assign ov_fall_pulse    = fall_q;

endmodule

// File: tb/tb_line_filter_edge_detect.sv
// Randomized and directed bench for line_filter_edge_detect against a run-length
// reference model of the filter rules.
module tb_line_filter_edge_detect;

    localparam int LN = 3;
    localparam int FW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [LN-1:0]     iv_linein;
    logic              i_filter_en;
    logic [LN*FW-1:0]  iv_filter_rise;
    logic [LN*FW-1:0]  iv_filter_fall;
    logic [LN-1:0]     ov_linein_filter;
    logic [LN-1:0]     ov_rise_pulse;
    logic [LN-1:0]     ov_fall_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: filtered level, pulses, and length of the current mismatch run.
    logic [LN-1:0] m_filt, m_rise, m_fall;
    int unsigned   m_run [LN];

    line_filter_edge_detect #(.LINE_NUM(LN), .FILTER_WIDTH(FW)) dut (
        .clk              (clk),
        .reset            (reset),
        .iv_linein        (iv_linein),
        .i_filter_en      (i_filter_en),
        .iv_filter_rise   (iv_filter_rise),
        .iv_filter_fall   (iv_filter_fall),
        .ov_linein_filter (ov_linein_filter),
        .ov_rise_pulse    (ov_rise_pulse),
        .ov_fall_pulse    (ov_fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_filt = '0;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < LN; i++) m_run[i] = 0;
    endtask

    // Advance one clock edge; the model sees the inputs that the DUT sampled.
    // A line commits once it has already disagreed for at least thr earlier cycles.
    task automatic tick();
        int unsigned thr;
        @(posedge clk);
        for (int i = 0; i < LN; i++) begin
            if (!i_filter_en) thr = 0;
            else if (m_filt[i]) thr = iv_filter_fall[i*FW +: FW];
            else thr = iv_filter_rise[i*FW +: FW];
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (iv_linein[i] == m_filt[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] >= thr) begin
                m_filt[i] = iv_linein[i];
                m_rise[i] = iv_linein[i];
                m_fall[i] = !iv_linein[i];
                m_run[i]  = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
            end
        end
        #1;
    endtask

    task automatic set_thr(input int line, input int unsigned r, input int unsigned f);
        iv_filter_rise[line*FW +: FW] = FW'(r);
        iv_filter_fall[line*FW +: FW] = FW'(f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({ov_linein_filter, ov_rise_pulse, ov_fall_pulse} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b",
                     {ov_linein_filter, ov_rise_pulse, ov_fall_pulse}, 9'b0);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        iv_linein   = '0;
        i_filter_en = 1'b1;
        for (int i = 0; i < LN; i++) set_thr(i, 4, 4);
        do_reset();
        for (int k = 0; k < 100; k++) begin
            tick();
            n_checks++;
            if ({ov_linein_filter, ov_rise_pulse, ov_fall_pulse} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %b expected %b", k,
                         {ov_linein_filter, ov_rise_pulse, ov_fall_pulse}, 9'b0);
            end
        end
    endtask

    task automatic test_rise_line0();
        logic [LN-1:0] ef, er;
        iv_linein = 3'b001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            ef = (k >= 5) ? 3'b001 : 3'b000;
            er = (k == 5) ? 3'b001 : 3'b000;
            n_checks++;
            if ({ov_linein_filter, ov_rise_pulse, ov_fall_pulse} !== {ef, er, 3'b000}) begin
                n_fail++;
                $display("FAIL rise_line0 edge%0d: got %b expected %b", k,
                         {ov_linein_filter, ov_rise_pulse, ov_fall_pulse}, {ef, er, 3'b000});
            end
        end
    endtask

    task automatic test_fall_glitch();
        int lows [3] = '{3, 10, 11};
        set_thr(1, 0, 10);
        iv_linein[1] = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ov_linein_filter[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_setup: got %b expected 1", ov_linein_filter[1]);
        end
        for (int p = 0; p < 3; p++) begin
            iv_linein[1] = 1'b0;
            for (int k = 1; k <= lows[p]; k++) begin
                tick();
                n_checks++;
                if ({ov_linein_filter[1], ov_fall_pulse[1], ov_rise_pulse[1]} !==
                    {(k < 11), (k == 11), 1'b0}) begin
                    n_fail++;
                    $display("FAIL fall_glitch low%0d edge%0d: got %b expected %b", lows[p], k,
                             {ov_linein_filter[1], ov_fall_pulse[1], ov_rise_pulse[1]},
                             {(k < 11), (k == 11), 1'b0});
                end
            end
            if (p < 2) begin
                iv_linein[1] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    n_checks++;
                    if ({ov_linein_filter, ov_rise_pulse, ov_fall_pulse} !==
                        {m_filt, m_rise, m_fall}) begin
                        n_fail++;
                        $display("FAIL fall_glitch recover: got %b expected %b",
                                 {ov_linein_filter, ov_rise_pulse, ov_fall_pulse},
                                 {m_filt, m_rise, m_fall});
                    end
                end
            end
        end
    endtask

    task automatic test_bypass();
        i_filter_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            iv_linein[2] = ~iv_linein[2];
            tick();
            n_checks++;
            if ({ov_linein_filter[2], ov_rise_pulse[2], ov_fall_pulse[2]} !==
                {iv_linein[2], iv_linein[2], ~iv_linein[2]}) begin
                n_fail++;
                $display("FAIL bypass_toggle cyc%0d: got %b expected %b", k,
                         {ov_linein_filter[2], ov_rise_pulse[2], ov_fall_pulse[2]},
                         {iv_linein[2], iv_linein[2], ~iv_linein[2]});
            end
        end
        i_filter_en = 1'b1;
    endtask

    task automatic test_thr_lower();
        set_thr(0, 20, 0);
        iv_linein[0] = 1'b0;
        tick();
        tick();
        iv_linein[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if ({ov_linein_filter[0], ov_rise_pulse[0]} !== 2'b00) begin
                n_fail++;
                $display("FAIL thr_lower pending%0d: got %b expected 00", k,
                         {ov_linein_filter[0], ov_rise_pulse[0]});
            end
        end
        set_thr(0, 5, 0);
        tick();
        n_checks++;
        if ({ov_linein_filter[0], ov_rise_pulse[0], ov_fall_pulse[0]} !== 3'b110) begin
            n_fail++;
            $display("FAIL thr_lower commit: got %b expected 110",
                     {ov_linein_filter[0], ov_rise_pulse[0], ov_fall_pulse[0]});
        end
    endtask

    task automatic test_disable_pending();
        set_thr(0, 0, 50);
        iv_linein[0] = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        i_filter_en = 1'b0;
        tick();
        n_checks++;
        if ({ov_linein_filter[0], ov_rise_pulse[0], ov_fall_pulse[0]} !== 3'b001) begin
            n_fail++;
            $display("FAIL disable_pending: got %b expected 001",
                     {ov_linein_filter[0], ov_rise_pulse[0], ov_fall_pulse[0]});
        end
        i_filter_en = 1'b1;
    endtask

    task automatic test_saturation();
        logic ef, er;
        iv_linein = '0;
        do_reset();
        for (int i = 0; i < LN; i++) set_thr(i, 32'hFFFF, 32'hFFFF);
        iv_linein = 3'b001;
        for (int k = 1; k <= 65538; k++) begin
            tick();
            ef = (k >= 65536);
            er = (k == 65536);
            n_checks++;
            if ({ov_linein_filter, ov_rise_pulse, ov_fall_pulse} !==
                {2'b00, ef, 2'b00, er, 3'b000}) begin
                n_fail++;
                $display("FAIL saturation edge%0d: got %b expected %b", k,
                         {ov_linein_filter, ov_rise_pulse, ov_fall_pulse},
                         {2'b00, ef, 2'b00, er, 3'b000});
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        iv_linein = '0;
        do_reset();
        iv_linein = 3'b001;
        for (int k = 0; k < 3000; k++) tick();
        do_reset();
        // A stale count would commit on the first edge against the lowered threshold.
        set_thr(0, 10, 10);
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({ov_linein_filter[0], ov_rise_pulse[0]} !== {(k >= 11), (k == 11)}) begin
                n_fail++;
                $display("FAIL reset_mid_pending edge%0d: got %b expected %b", k,
                         {ov_linein_filter[0], ov_rise_pulse[0]}, {(k >= 11), (k == 11)});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < LN; i++) set_thr(i, 2, 3);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < LN; i++) begin
                if ($urandom_range(0, 3) == 0) iv_linein[i] = ~iv_linein[i];
                if ($urandom_range(0, 40) == 0)
                    set_thr(i, $urandom_range(0, 6), $urandom_range(0, 6));
            end
            i_filter_en = ($urandom_range(0, 31) != 0);
            tick();
            n_checks++;
            if ({ov_linein_filter, ov_rise_pulse, ov_fall_pulse} !== {m_filt, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b expected %b", k,
                         {ov_linein_filter, ov_rise_pulse, ov_fall_pulse},
                         {m_filt, m_rise, m_fall});
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        iv_linein      = '0;
        i_filter_en    = 1'b1;
        iv_filter_rise = '0;
        iv_filter_fall = '0;
        model_clear();
        #3;
        test_reset();
        test_rise_line0();
        test_fall_glitch();
        test_bypass();
        test_thr_lower();
        test_disable_pending();
        test_random();
        test_saturation();
        test_reset_mid_pending();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
